// File: rtl/pipe_control.sv
// pipe_control: main-control decode for the five-stage RV32I core.
// Decodes the ID opcode, carries the control bundle through the ID/EX,
// EX/MEM and MEM/WB registers, detects load-use hazards, resolves branches
// in ID and keeps a saturating count of illegal opcodes.
module pipe_control #(
    parameter int ALUOP_W       = 2,
    parameter int RD_W          = 5,
    parameter int ENABLE_BRANCH = 1,
    parameter int CNT_W         = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [6:0]         Op_i,
    input  logic [RD_W-1:0]    RS1_i,
    input  logic [RD_W-1:0]    RS2_i,
    input  logic [RD_W-1:0]    RD_i,
    input  logic               Equal_i,
    output logic               Stall_o,
    output logic               Flush_o,
    output logic               Branch_o,
    output logic               PCWrite_o,
    output logic               IFIDWrite_o,
    output logic [ALUOP_W-1:0] EX_ALUOp_o,
    output logic               EX_ALUSrc_o,
    output logic               EX_RegWrite_o,
    output logic               EX_MemRead_o,
    output logic               EX_MemWrite_o,
    output logic               EX_MemToReg_o,
    output logic [RD_W-1:0]    EX_RD_o,
    output logic               MEM_RegWrite_o,
    output logic               MEM_MemRead_o,
    output logic               MEM_MemWrite_o,
    output logic               MEM_MemToReg_o,
    output logic [RD_W-1:0]    MEM_RD_o,
    output logic               WB_RegWrite_o,
    output logic               WB_MemToReg_o,
    output logic [RD_W-1:0]    WB_RD_o,
    output logic [CNT_W-1:0]   IllegalCnt_o
);

    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       use_rs1;
        logic       use_rs2;
        logic       illegal;
    } ctrl_t;

    // Opcode to control bundle; unknown non-zero opcodes flag illegal.
    function automatic ctrl_t decode(input logic [6:0] op);
        ctrl_t c;
        c = '{alu_op: 2'b00, default: 1'b0};
        case (op)
            OP_NOP: begin
                c.illegal = 1'b0;
            end
            OP_R: begin
                c.alu_op = 2'b00; c.reg_write = 1'b1;
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
            end
            OP_I: begin
                c.alu_op = 2'b01; c.alu_src = 1'b1; c.reg_write = 1'b1;
                c.use_rs1 = 1'b1;
            end
            OP_LOAD: begin
                c.alu_op = 2'b01; c.alu_src = 1'b1; c.reg_write = 1'b1;
                c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.use_rs1 = 1'b1;
            end
            OP_STORE: begin
                c.alu_op = 2'b10; c.alu_src = 1'b1; c.mem_write = 1'b1;
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                if (ENABLE_BRANCH != 0) begin
                    c.alu_op = 2'b11; c.branch = 1'b1;
                    c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
                end else begin
                    c.illegal = 1'b1;
                end
            end
            default: begin
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

    ctrl_t            dec_s;
    logic             hz_s;
    logic             rs1_hit_s;
    logic             rs2_hit_s;
    logic             bubble_s;
    logic             cnt_inc_s;
    logic [RD_W-1:0]  ex_rd_next_s;

    // Decode of the live ID instruction plus load-use hazard detection.
    always_comb begin
        dec_s     = decode(OP_NOP);
        hz_s      = 1'b0;
        rs1_hit_s = 1'b0;
        rs2_hit_s = 1'b0;
        if (start_i) begin
            dec_s = decode(Op_i);
        end else begin
            dec_s = decode(OP_NOP);
        end
        rs1_hit_s = dec_s.use_rs1 && (RS1_i == EX_RD_o);
        rs2_hit_s = dec_s.use_rs2 && (RS2_i == EX_RD_o);
        if (start_i && EX_MemRead_o && (EX_RD_o != {RD_W{1'b0}})) begin
            hz_s = rs1_hit_s || rs2_hit_s;
        end else begin
            hz_s = 1'b0;
        end
    end

    // Hazard/branch controls, bubble select and counter enable.
    always_comb begin
        Stall_o      = hz_s;
        PCWrite_o    = ~hz_s;
        IFIDWrite_o  = ~hz_s;
        Branch_o     = dec_s.branch && start_i && !hz_s;
        Flush_o      = 1'b0;
        bubble_s     = hz_s || !start_i;
        cnt_inc_s    = 1'b0;
        ex_rd_next_s = {RD_W{1'b0}};
        if (Branch_o && Equal_i) begin
            Flush_o = 1'b1;
        end else begin
            Flush_o = 1'b0;
        end
        if (dec_s.reg_write) begin
            ex_rd_next_s = RD_i;
        end else begin
            ex_rd_next_s = {RD_W{1'b0}};
        end
        if (start_i && !hz_s && dec_s.illegal && (IllegalCnt_o != {CNT_W{1'b1}})) begin
            cnt_inc_s = 1'b1;
        end else begin
            cnt_inc_s = 1'b0;
        end
    end

    // ID/EX register: loads the decoded bundle, or a bubble on hazard/idle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            EX_ALUOp_o    <= {ALUOP_W{1'b0}};
            EX_ALUSrc_o   <= 1'b0;
            EX_RegWrite_o <= 1'b0;
            EX_MemRead_o  <= 1'b0;
            EX_MemWrite_o <= 1'b0;
            EX_MemToReg_o <= 1'b0;
            EX_RD_o       <= {RD_W{1'b0}};
        end else if (bubble_s) begin
            EX_ALUOp_o    <= {ALUOP_W{1'b0}};
            EX_ALUSrc_o   <= 1'b0;
            EX_RegWrite_o <= 1'b0;
            EX_MemRead_o  <= 1'b0;
            EX_MemWrite_o <= 1'b0;
            EX_MemToReg_o <= 1'b0;
            EX_RD_o       <= {RD_W{1'b0}};
        end else begin
            EX_ALUOp_o    <= ALUOP_W'(dec_s.alu_op);
            EX_ALUSrc_o   <= dec_s.alu_src;
            EX_RegWrite_o <= dec_s.reg_write;
            EX_MemRead_o  <= dec_s.mem_read;
            EX_MemWrite_o <= dec_s.mem_write;
            EX_MemToReg_o <= dec_s.mem_to_reg;
            EX_RD_o       <= ex_rd_next_s;
        end
    end

    // EX/MEM and MEM/WB registers advance every cycle, stalls included.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            MEM_RegWrite_o <= 1'b0;
            MEM_MemRead_o  <= 1'b0;
            MEM_MemWrite_o <= 1'b0;
            MEM_MemToReg_o <= 1'b0;
            MEM_RD_o       <= {RD_W{1'b0}};
            WB_RegWrite_o  <= 1'b0;
            WB_MemToReg_o  <= 1'b0;
            WB_RD_o        <= {RD_W{1'b0}};
        end else begin
            MEM_RegWrite_o <= EX_RegWrite_o;
            MEM_MemRead_o  <= EX_MemRead_o;
            MEM_MemWrite_o <= EX_MemWrite_o;
            MEM_MemToReg_o <= EX_MemToReg_o;
            MEM_RD_o       <= EX_RD_o;
            WB_RegWrite_o  <= MEM_RegWrite_o;
            WB_MemToReg_o  <= MEM_MemToReg_o;
            WB_RD_o        <= MEM_RD_o;
        end
    end

    // Saturating illegal-opcode counter; a stalled instruction counts once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            IllegalCnt_o <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            IllegalCnt_o <= IllegalCnt_o + CNT_W'(1);
        end else begin
            IllegalCnt_o <= IllegalCnt_o;
        end
    end

endmodule

// File: tb/tb_pipe_control.sv
// Directed testbench for pipe_control with hand-computed expectations.
// A second instance with ENABLE_BRANCH=0 shares the stimulus.
module tb_pipe_control;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] op = 7'b0000000;
    logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
    logic       equal = 1'b0;

    logic       stall, flush, branch, pc_write, ifid_write;
    logic [1:0] ex_aluop;
    logic       ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [4:0] ex_rd;
    logic       mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg;
    logic [4:0] mem_rd;
    logic       wb_regwrite, wb_memtoreg;
    logic [4:0] wb_rd;
    logic [7:0] illegal_cnt;

    logic       d2_stall, d2_flush, d2_branch, d2_pc_write, d2_ifid_write;
    logic [1:0] d2_ex_aluop;
    logic       d2_ex_alusrc, d2_ex_regwrite, d2_ex_memread, d2_ex_memwrite, d2_ex_memtoreg;
    logic [4:0] d2_ex_rd;
    logic       d2_mem_regwrite, d2_mem_memread, d2_mem_memwrite, d2_mem_memtoreg;
    logic [4:0] d2_mem_rd;
    logic       d2_wb_regwrite, d2_wb_memtoreg;
    logic [4:0] d2_wb_rd;
    logic [7:0] d2_illegal_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_control #(.ALUOP_W(2), .RD_W(5), .ENABLE_BRANCH(1), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .Op_i(op),
        .RS1_i(rs1), .RS2_i(rs2), .RD_i(rd), .Equal_i(equal),
        .Stall_o(stall), .Flush_o(flush), .Branch_o(branch),
        .PCWrite_o(pc_write), .IFIDWrite_o(ifid_write),
        .EX_ALUOp_o(ex_aluop), .EX_ALUSrc_o(ex_alusrc), .EX_RegWrite_o(ex_regwrite),
        .EX_MemRead_o(ex_memread), .EX_MemWrite_o(ex_memwrite),
        .EX_MemToReg_o(ex_memtoreg), .EX_RD_o(ex_rd),
        .MEM_RegWrite_o(mem_regwrite), .MEM_MemRead_o(mem_memread),
        .MEM_MemWrite_o(mem_memwrite), .MEM_MemToReg_o(mem_memtoreg), .MEM_RD_o(mem_rd),
        .WB_RegWrite_o(wb_regwrite), .WB_MemToReg_o(wb_memtoreg), .WB_RD_o(wb_rd),
        .IllegalCnt_o(illegal_cnt)
    );

    pipe_control #(.ALUOP_W(2), .RD_W(5), .ENABLE_BRANCH(0), .CNT_W(8)) dut_nobr (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .Op_i(op),
        .RS1_i(rs1), .RS2_i(rs2), .RD_i(rd), .Equal_i(equal),
        .Stall_o(d2_stall), .Flush_o(d2_flush), .Branch_o(d2_branch),
        .PCWrite_o(d2_pc_write), .IFIDWrite_o(d2_ifid_write),
        .EX_ALUOp_o(d2_ex_aluop), .EX_ALUSrc_o(d2_ex_alusrc), .EX_RegWrite_o(d2_ex_regwrite),
        .EX_MemRead_o(d2_ex_memread), .EX_MemWrite_o(d2_ex_memwrite),
        .EX_MemToReg_o(d2_ex_memtoreg), .EX_RD_o(d2_ex_rd),
        .MEM_RegWrite_o(d2_mem_regwrite), .MEM_MemRead_o(d2_mem_memread),
        .MEM_MemWrite_o(d2_mem_memwrite), .MEM_MemToReg_o(d2_mem_memtoreg), .MEM_RD_o(d2_mem_rd),
        .WB_RegWrite_o(d2_wb_regwrite), .WB_MemToReg_o(d2_wb_memtoreg), .WB_RD_o(d2_wb_rd),
        .IllegalCnt_o(d2_illegal_cnt)
    );

    // Count one comparison and report it if observed differs from expected.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [6:0] o, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d);
        start = s; op = o; rs1 = a; rs2 = b; rd = d;
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        check_val("rst_ex_regwrite", {31'd0, ex_regwrite}, 32'd0);
        check_val("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        check_val("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check_val("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
        check_val("rst_pcwrite", {31'd0, pc_write}, 32'd1);
        check_val("rst_ifidwrite", {31'd0, ifid_write}, 32'd1);
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_branch", {31'd0, branch}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // R-type rd=3 flows EX -> MEM -> WB
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
        step();
        check_val("r_ex_regwrite", {31'd0, ex_regwrite}, 32'd1);
        check_val("r_ex_rd", {27'd0, ex_rd}, 32'd3);
        check_val("r_ex_aluop", {30'd0, ex_aluop}, 32'd0);
        check_val("r_ex_alusrc", {31'd0, ex_alusrc}, 32'd0);
        drive(1'b0, OP_R, 5'd1, 5'd2, 5'd3);
        check_val("idle_pcwrite", {31'd0, pc_write}, 32'd1);
        step();
        check_val("r_mem_rd", {27'd0, mem_rd}, 32'd3);
        check_val("r_mem_regwrite", {31'd0, mem_regwrite}, 32'd1);
        check_val("idle_ex_bubble", {31'd0, ex_regwrite}, 32'd0);
        step();
        check_val("r_wb_regwrite", {31'd0, wb_regwrite}, 32'd1);
        check_val("r_wb_rd", {27'd0, wb_rd}, 32'd3);

        // LOAD rd=5 then R-type consuming rs2=5: one-cycle stall
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5);
        step();
        check_val("ld_ex_memread", {31'd0, ex_memread}, 32'd1);
        check_val("ld_ex_memtoreg", {31'd0, ex_memtoreg}, 32'd1);
        check_val("ld_ex_aluop", {30'd0, ex_aluop}, 32'd1);
        check_val("ld_ex_rd", {27'd0, ex_rd}, 32'd5);
        drive(1'b1, OP_R, 5'd1, 5'd5, 5'd6);
        check_val("lu_stall", {31'd0, stall}, 32'd1);
        check_val("lu_pcwrite", {31'd0, pc_write}, 32'd0);
        check_val("lu_ifidwrite", {31'd0, ifid_write}, 32'd0);
        step();
        check_val("lu_bubble_regwrite", {31'd0, ex_regwrite}, 32'd0);
        check_val("lu_bubble_memread", {31'd0, ex_memread}, 32'd0);
        check_val("lu_bubble_rd", {27'd0, ex_rd}, 32'd0);
        check_val("lu_mem_memread", {31'd0, mem_memread}, 32'd1);
        check_val("lu_unstall", {31'd0, stall}, 32'd0);
        step();
        check_val("lu_r_in_ex", {31'd0, ex_regwrite}, 32'd1);
        check_val("lu_r_rd", {27'd0, ex_rd}, 32'd6);

        // LOAD rd=0 never stalls its consumer
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0);
        step();
        drive(1'b1, OP_R, 5'd0, 5'd2, 5'd7);
        check_val("ld0_nostall", {31'd0, stall}, 32'd0);
        // I-type does not use rs2
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5);
        step();
        drive(1'b1, OP_I, 5'd1, 5'd5, 5'd5);
        check_val("itype_rs2_nostall", {31'd0, stall}, 32'd0);
        step();
        check_val("itype_alusrc", {31'd0, ex_alusrc}, 32'd1);

        // Branch resolution and flush
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd7);
        step();
        equal = 1'b1;
        drive(1'b1, OP_BRANCH, 5'd1, 5'd2, 5'd9);
        check_val("br_eq_branch", {31'd0, branch}, 32'd1);
        check_val("br_eq_flush", {31'd0, flush}, 32'd1);
        check_val("nobr_branch", {31'd0, d2_branch}, 32'd0);
        equal = 1'b0;
        #1;
        check_val("br_ne_branch", {31'd0, branch}, 32'd1);
        check_val("br_ne_flush", {31'd0, flush}, 32'd0);
        step();
        check_val("br_ex_aluop", {30'd0, ex_aluop}, 32'd3);
        check_val("br_ex_rd_zeroed", {27'd0, ex_rd}, 32'd0);
        check_val("br_ex_regwrite", {31'd0, ex_regwrite}, 32'd0);
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd4);
        step();
        equal = 1'b1;
        drive(1'b1, OP_BRANCH, 5'd4, 5'd2, 5'd0);
        check_val("br_hz_branch", {31'd0, branch}, 32'd0);
        check_val("br_hz_flush", {31'd0, flush}, 32'd0);
        check_val("br_hz_stall", {31'd0, stall}, 32'd1);
        step();
        check_val("br_after_stall", {31'd0, branch}, 32'd1);
        check_val("br_cnt_enabled", {24'd0, illegal_cnt}, 32'd0);
        check_val("br_cnt_disabled", {24'd0, d2_illegal_cnt}, 32'd2);

        // Illegal opcode held for 300 cycles saturates at 255
        equal = 1'b0;
        drive(1'b1, OP_BAD, 5'd0, 5'd0, 5'd0);
        step();
        check_val("ill_cnt_1", {24'd0, illegal_cnt}, 32'd1);
        check_val("ill_ex_bubble", {31'd0, ex_regwrite}, 32'd0);
        for (int i = 0; i < 299; i++) step();
        check_val("ill_cnt_sat", {24'd0, illegal_cnt}, 32'd255);

        // Reset pulse between edges clears pipeline and counter at once
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
        step();
        step();
        check_val("pre_rst_mem_rd", {27'd0, mem_rd}, 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ex_regwrite", {31'd0, ex_regwrite}, 32'd0);
        check_val("mid_rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        check_val("mid_rst_mem_rd", {27'd0, mem_rd}, 32'd0);
        check_val("mid_rst_mem_regwrite", {31'd0, mem_regwrite}, 32'd0);
        check_val("mid_rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        check_val("mid_rst_cnt", {24'd0, illegal_cnt}, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined main-control unit for the five-stage RV32I core. It decodes the ID-stage opcode and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers, so downstream stages read registered controls rather than re-decoding. It also detects load-use hazards, inserting a bubble and freezing PC and IF/ID. Branches are resolved in ID, and a taken branch flushes IF/ID. A saturating counter tracks illegal opcodes.

## Interface
- ALUOP_W, 2: ALUOp field width; encodings below are zero-extended.
- RD_W, 5: register-index width.
- ENABLE_BRANCH, 1: 1 decodes opcode 1100011; 0 treats it as illegal.
- CNT_W, 8: illegal-opcode counter width.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- start_i  in  1  1 means the ID instruction is live; 0 decodes ID as NOP.
- Op_i  in  7  ID opcode, Ins[6:0].
- RS1_i, RS2_i, RD_i  in  RD_W each  ID source and destination indices.
- Equal_i  in  1  ID register-compare result for the branch.
- Stall_o, Flush_o, Branch_o, PCWrite_o, IFIDWrite_o  out  1 each  combinational hazard and branch controls.
- EX_ALUOp_o  out  ALUOP_W; EX_ALUSrc_o, EX_RegWrite_o, EX_MemRead_o, EX_MemWrite_o, EX_MemToReg_o  out  1 each; EX_RD_o  out  RD_W  ID/EX register.
- MEM_RegWrite_o, MEM_MemRead_o, MEM_MemWrite_o, MEM_MemToReg_o  out  1 each; MEM_RD_o  out  RD_W  EX/MEM register.
- WB_RegWrite_o, WB_MemToReg_o  out  1 each; WB_RD_o  out  RD_W  MEM/WB register.
- IllegalCnt_o  out  CNT_W  saturating illegal-opcode count.

## Operation
- Decode (ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg, Branch):
  - R 0110011: 00,0,1,0,0,0,0.
  - I 0010011: 01,1,1,0,0,0,0.
  - LOAD 0000011: 01,1,1,1,0,1,0.
  - STORE 0100011: 10,1,0,0,1,0,0.
  - BRANCH 1100011 (ENABLE_BRANCH=1): 11,0,0,0,0,0,1.
- All other opcodes, and 0000000 (NOP), decode to all zeros.
- Use flags:
  - rs1 is used by R, I, LOAD, STORE and BRANCH.
  - rs2 is used by R, STORE and BRANCH.
- Load-use hazard (hz): start_i=1, EX_MemRead_o=1, EX_RD_o≠0, and EX_RD_o matches a used source (RS1_i, or RS2_i when rs2 is used).
- While hz=1:
  - Stall_o=1, PCWrite_o=0, IFIDWrite_o=0.
  - A bubble (all controls and RD zero) is clocked into ID/EX.
- Branch:
  - Branch_o = decoded Branch & start_i & ~hz.
  - Flush_o = Branch_o & Equal_i.
  - Branch_o and Flush_o are never asserted while stalled.
- start_i=0:
  - ID decodes as NOP, and Stall_o=Flush_o=Branch_o=0.
  - PCWrite_o=IFIDWrite_o=1.
  - The later stages keep advancing and drain.
- A bubble also enters ID/EX for NOP and illegal opcodes. RD is zeroed whenever RegWrite=0.
- EX/MEM and MEM/WB advance unconditionally every cycle, including during a stall.
- IllegalCnt_o:
  - Increments on each cycle with start_i=1, hz=0 and an illegal non-zero opcode.
  - A stalled illegal instruction counts once, on its unstalled cycle.
  - Saturates at 2^CNT_W−1.

## Timing
- Reset (rst_i low): every pipeline-register output and IllegalCnt_o is cleared to 0 asynchronously. With start_i=0 the combinational outputs are PCWrite_o=IFIDWrite_o=1 and all others 0.
- Latency: decode → EX_* 1 cycle, MEM_* 2 cycles, WB_* 3 cycles.
- Stall_o, Flush_o, Branch_o, PCWrite_o and IFIDWrite_o are combinational within the ID cycle.
- A stall lasts exactly 1 cycle for one load. The next cycle sees a bubble in EX, so hz=0 and the held instruction proceeds.
- Back-to-back loads into the same rd each stall only their own consumer.
- Stall and branch in the same cycle: the stall wins. The branch re-evaluates on the next cycle.
- Reset asserted mid-operation: all in-flight controls are lost, with no partial writes flagged.

## Test plan
- Reset, then R-type (Op_i=0110011, RD_i=3) with start_i=1:
  - EX_RegWrite_o=1, EX_RD_o=3 at +1.
  - MEM_RD_o=3 at +2.
  - WB_RegWrite_o=1, WB_RD_o=3 at +3.
- LOAD rd=5, then R-type with RS2_i=5:
  - Stall_o=1, PCWrite_o=0 for one cycle.
  - EX_* all 0 at +1.
  - R-type appears in EX 1 cycle later.
- LOAD rd=0, then consumer with RS1_i=0 → no stall. I-type rd=5 with RS2_i=5 after LOAD rd=5 → no stall (rs2 unused).
- BRANCH with Equal_i=1 → Branch_o=1, Flush_o=1. With Equal_i=0 → Flush_o=0. Same branch under load-use hazard → Branch_o=0, Stall_o=1.
- Opcode 1111111 held for 300 cycles with CNT_W=8 → IllegalCnt_o saturates at 255. ENABLE_BRANCH=0 → 1100011 increments the counter.
- rst_i pulsed low mid-stream for <1 cycle between edges → all EX/MEM/WB outputs and the counter read 0 immediately.
